// File: rtl/clock_set_ctrl.sv
// Front-panel time-setting controller: debounces the edit buttons, holds an edit
// buffer for hh:mm:ss, moves a digit cursor and hands the result to the timekeeper.
//
// state   | meaning
// IDLE    | not editing; button events ignored, waits for set_mod rise
// CAPTURE | copy running time into the edit buffer, reset cursor and blink
// EDIT    | buttons move the cursor and adjust the selected digit
// COMMIT  | one-cycle load of the edit buffer into the timekeeper
module clock_set_ctrl #(
    parameter int DEBOUNCE_CYCLES   = 1000000,
    parameter int BLINK_HALF_PERIOD = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       set_mod,
    input  logic       left,
    input  logic       right,
    input  logic       up,
    input  logic       down,
    input  logic [5:0] cur_hours,
    input  logic [5:0] cur_minutes,
    input  logic [5:0] cur_seconds,
    output logic [5:0] set_hours,
    output logic [5:0] set_minutes,
    output logic [5:0] set_seconds,
    output logic       load,
    output logic       editing,
    output logic [2:0] pos,
    output logic [5:0] blink_mask
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BW = $clog2(BLINK_HALF_PERIOD + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BW-1:0] BL_LAST = BW'(BLINK_HALF_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, EDIT, COMMIT} state_t;

    // bit 0 = set_mod, bits 1..4 = left, right, up, down
    logic [4:0]    raw;
    logic [4:0]    sync_a;
    logic [4:0]    sync_b;
    logic          mod_d;
    logic [3:0]    btn_lvl;
    logic [3:0]    btn_lvl_d;
    logic [3:0]    btn_evt;
    logic [DW-1:0] db_cnt [4];

    assign raw = {down, up, right, left, set_mod};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a    <= '0;
            sync_b    <= '0;
            mod_d     <= 1'b0;
            btn_lvl   <= '0;
            btn_lvl_d <= '0;
            btn_evt   <= '0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            sync_a    <= raw;
            sync_b    <= sync_a;
            mod_d     <= sync_b[0];
            btn_lvl_d <= btn_lvl;
            btn_evt   <= btn_lvl & ~btn_lvl_d;
            for (int i = 0; i < 4; i++) begin
                if (sync_b[i+1] == btn_lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_cnt[i]  <= '0;
                    btn_lvl[i] <= ~btn_lvl[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
            end
        end
    end

    logic mod_rise;
    logic mod_fall;
    logic ev_left;
    logic ev_right;
    logic ev_up;
    logic ev_down;
    logic ev_any;

    assign mod_rise = sync_b[0] & ~mod_d;
    assign mod_fall = ~sync_b[0] & mod_d;
    // opposing presses in the same cycle cancel each other
    assign ev_left  = btn_evt[0] & ~btn_evt[1];
    assign ev_right = btn_evt[1] & ~btn_evt[0];
    assign ev_up    = btn_evt[2] & ~btn_evt[3];
    assign ev_down  = btn_evt[3] & ~btn_evt[2];
    assign ev_any   = ev_left | ev_right | ev_up | ev_down;

    logic [6:0] field;
    logic [6:0] step;
    logic [6:0] modulus;
    logic [6:0] sum;
    logic [6:0] diff;
    logic [5:0] next_val;
    logic [2:0] pos_next;

    always_comb begin
        case (pos[2:1])
            2'd0:    field = {1'b0, set_seconds};
            2'd1:    field = {1'b0, set_minutes};
            default: field = {1'b0, set_hours};
        endcase
        step     = pos[0] ? 7'd10 : 7'd1;
        modulus  = (pos[2:1] == 2'd2) ? 7'd24 : 7'd60;
        sum      = field + step;
        diff     = field - step;
        next_val = 6'(field);
        // field < modulus and step <= 10, so one correction lands back in range
        if (ev_up) begin
            next_val = (sum >= modulus) ? 6'(sum - modulus) : 6'(sum);
        end else if (ev_down) begin
            next_val = diff[6] ? 6'(diff + modulus) : 6'(diff);
        end
        pos_next = pos;
        if (ev_left) begin
            pos_next = (pos == 3'd5) ? 3'd0 : pos + 3'd1;
        end else if (ev_right) begin
            pos_next = (pos == 3'd0) ? 3'd5 : pos - 3'd1;
        end
    end

    state_t        state;
    logic [BW-1:0] blink_cnt;
    logic          blank;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            set_hours   <= '0;
            set_minutes <= '0;
            set_seconds <= '0;
            load        <= 1'b0;
            editing     <= 1'b0;
            pos         <= '0;
            blink_mask  <= '0;
            blink_cnt   <= '0;
            blank       <= 1'b0;
        end else begin
            load <= 1'b0;
            case (state)
                IDLE: begin
                    if (mod_rise) begin
                        state   <= CAPTURE;
                        editing <= 1'b1;
                    end
                end
                CAPTURE: begin
                    set_hours   <= (cur_hours   >= 6'd24) ? 6'd0 : cur_hours;
                    set_minutes <= (cur_minutes >= 6'd60) ? 6'd0 : cur_minutes;
                    set_seconds <= (cur_seconds >= 6'd60) ? 6'd0 : cur_seconds;
                    pos         <= '0;
                    blink_cnt   <= '0;
                    blank       <= 1'b0;
                    blink_mask  <= '0;
                    state       <= EDIT;
                end
                EDIT: begin
                    if (mod_fall) begin
                        state      <= COMMIT;
                        load       <= 1'b1;
                        blink_mask <= '0;
                    end else begin
                        case (pos[2:1])
                            2'd0:    set_seconds <= next_val;
                            2'd1:    set_minutes <= next_val;
                            default: set_hours   <= next_val;
                        endcase
                        pos <= pos_next;
                        // any accepted press makes the digit visible right away
                        if (ev_any) begin
                            blink_cnt  <= '0;
                            blank      <= 1'b0;
                            blink_mask <= '0;
                        end else if (blink_cnt == BL_LAST) begin
                            blink_cnt  <= '0;
                            blank      <= ~blank;
                            blink_mask <= blank ? 6'd0 : (6'd1 << pos_next);
                        end else begin
                            blink_cnt  <= blink_cnt + BW'(1);
                            blink_mask <= blank ? (6'd1 << pos_next) : 6'd0;
                        end
                    end
                end
                COMMIT: begin
                    state   <= IDLE;
                    editing <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: directed front-panel scenarios with literal checks, then
// random button/switch traffic, all compared every cycle against a behavioural model.
module tb_clock_set_ctrl;

    localparam int D = 4;
    localparam int B = 8;
    localparam int M_IDLE    = 0;
    localparam int M_CAPTURE = 1;
    localparam int M_EDIT    = 2;
    localparam int M_COMMIT  = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       set_mod = 1'b0;
    logic       left = 1'b0;
    logic       right = 1'b0;
    logic       up = 1'b0;
    logic       down = 1'b0;
    logic [5:0] cur_hours = '0;
    logic [5:0] cur_minutes = '0;
    logic [5:0] cur_seconds = '0;
    logic [5:0] set_hours;
    logic [5:0] set_minutes;
    logic [5:0] set_seconds;
    logic       load;
    logic       editing;
    logic [2:0] pos;
    logic [5:0] blink_mask;

    clock_set_ctrl #(.DEBOUNCE_CYCLES(D), .BLINK_HALF_PERIOD(B)) dut (
        .clk(clk), .reset(reset), .set_mod(set_mod), .left(left), .right(right),
        .up(up), .down(down), .cur_hours(cur_hours), .cur_minutes(cur_minutes),
        .cur_seconds(cur_seconds), .set_hours(set_hours), .set_minutes(set_minutes),
        .set_seconds(set_seconds), .load(load), .editing(editing), .pos(pos),
        .blink_mask(blink_mask)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    int load_seen = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: inputs reach the logic two cycles late, a button level
    // flips after D consecutive disagreeing cycles, and a press is acted on two
    // cycles after its level flips. Fields are plain integers with modulo arithmetic.
    bit s1[5], s2[5], mod_prev;
    bit lvl[4], lvl_old[4], evt[4];
    int run[4];
    int mode, mpos, bcnt;
    bit blank;
    int fld[3];
    bit rise, fall, e_l, e_r, e_u, e_d;
    int f, step, md;

    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 5; k++) begin s1[k] = 0; s2[k] = 0; end
            for (int k = 0; k < 4; k++) begin lvl[k] = 0; lvl_old[k] = 0; evt[k] = 0; run[k] = 0; end
            mod_prev = 0; mode = M_IDLE; mpos = 0; bcnt = 0; blank = 0;
            for (int k = 0; k < 3; k++) fld[k] = 0;
        end else begin
            rise = s2[0] && !mod_prev;
            fall = !s2[0] && mod_prev;
            case (mode)
                M_IDLE: if (rise) mode = M_CAPTURE;
                M_CAPTURE: begin
                    fld[0] = (cur_seconds < 60) ? int'(cur_seconds) : 0;
                    fld[1] = (cur_minutes < 60) ? int'(cur_minutes) : 0;
                    fld[2] = (cur_hours < 24) ? int'(cur_hours) : 0;
                    mpos = 0; bcnt = 0; blank = 0; mode = M_EDIT;
                end
                M_EDIT: begin
                    if (fall) mode = M_COMMIT;
                    else begin
                        e_l = evt[0] && !evt[1];
                        e_r = evt[1] && !evt[0];
                        e_u = evt[2] && !evt[3];
                        e_d = evt[3] && !evt[2];
                        f = mpos / 2;
                        step = (mpos % 2 == 1) ? 10 : 1;
                        md = (f == 2) ? 24 : 60;
                        if (e_u) fld[f] = (fld[f] + step) % md;
                        if (e_d) fld[f] = (fld[f] - step + md) % md;
                        if (e_l) mpos = (mpos + 1) % 6;
                        if (e_r) mpos = (mpos + 5) % 6;
                        if (e_l || e_r || e_u || e_d) begin
                            bcnt = 0; blank = 0;
                        end else begin
                            bcnt++;
                            if (bcnt == B) begin bcnt = 0; blank = !blank; end
                        end
                    end
                end
                default: mode = M_IDLE;
            endcase
            for (int k = 0; k < 4; k++) begin
                evt[k] = lvl[k] && !lvl_old[k];
                lvl_old[k] = lvl[k];
                if (s2[k+1] != lvl[k]) begin
                    run[k]++;
                    if (run[k] == D) begin run[k] = 0; lvl[k] = !lvl[k]; end
                end else begin
                    run[k] = 0;
                end
            end
            mod_prev = s2[0];
            for (int k = 0; k < 5; k++) s2[k] = s1[k];
            s1[0] = set_mod; s1[1] = left; s1[2] = right; s1[3] = up; s1[4] = down;
        end
    end

    always @(negedge clk) begin
        if (load) load_seen++;
        if (chk_en) begin
            check("set_hours", int'(set_hours), fld[2]);
            check("set_minutes", int'(set_minutes), fld[1]);
            check("set_seconds", int'(set_seconds), fld[0]);
            check("load", int'(load), (mode == M_COMMIT) ? 1 : 0);
            check("editing", int'(editing), (mode != M_IDLE) ? 1 : 0);
            check("pos", int'(pos), mpos);
            check("blink_mask", int'(blink_mask), (mode == M_EDIT && blank) ? (1 << mpos) : 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic press(input bit l, input bit r, input bit u, input bit d, input int hold);
        left = l; right = r; up = u; down = d;
        tick(hold);
        left = 0; right = 0; up = 0; down = 0;
        tick(14);
    endtask

    int rr;

    initial begin
        cur_hours = 12; cur_minutes = 34; cur_seconds = 56;
        tick(3);
        chk_en = 1'b1;
        check("rst_editing", int'(editing), 0);
        check("rst_load", int'(load), 0);
        check("rst_hours", int'(set_hours), 0);
        check("rst_pos", int'(pos), 0);
        check("rst_mask", int'(blink_mask), 0);
        reset = 0;
        tick(2);

        // capture 12:34:56
        set_mod = 1;
        tick(2);
        check("editing_early", int'(editing), 0);
        tick(1);
        check("editing_3clk", int'(editing), 1);
        tick(1);
        check("cap_hours", int'(set_hours), 12);
        check("cap_minutes", int'(set_minutes), 34);
        check("cap_seconds", int'(set_seconds), 56);
        check("cap_pos", int'(pos), 0);
        check("cap_load", int'(load), 0);

        // cursor to minute tens, adjust by tens with wrap
        repeat (3) press(1, 0, 0, 0, 6);
        check("pos_after_left3", int'(pos), 3);
        repeat (2) press(0, 0, 1, 0, 6);
        check("min_54", int'(set_minutes), 54);
        press(0, 0, 1, 0, 6);
        check("min_wrap_4", int'(set_minutes), 4);

        // hours: 12 -> 22 -> 20, then tens up wraps to 6
        repeat (2) press(1, 0, 0, 0, 6);
        press(0, 0, 1, 0, 6);
        press(0, 1, 0, 0, 6);
        repeat (2) press(0, 0, 0, 1, 6);
        press(1, 0, 0, 0, 6);
        check("hr20_pos5", int'(pos), 5);
        press(0, 0, 1, 0, 6);
        check("hr_wrap_6", int'(set_hours), 6);
        press(1, 0, 0, 0, 6);
        check("pos_wrap_0", int'(pos), 0);
        press(0, 1, 0, 0, 6);
        check("pos_wrap_5", int'(pos), 5);
        press(0, 1, 0, 0, 6);
        repeat (6) press(0, 0, 0, 1, 6);
        check("hr_zero", int'(set_hours), 0);
        press(0, 0, 0, 1, 6);
        check("hr_wrap_23", int'(set_hours), 23);

        // cancelled pair, glitch, then a clean long press
        press(0, 0, 1, 1, 6);
        check("updown_cancel", int'(set_hours), 23);
        press(0, 0, 1, 0, 2);
        check("glitch_ignored", int'(set_hours), 23);
        press(0, 0, 1, 0, 6);
        check("one_increment", int'(set_hours), 0);

        // commit
        load_seen = 0;
        set_mod = 0;
        tick(2);
        check("load_not_yet", int'(load), 0);
        tick(1);
        check("load_pulse", int'(load), 1);
        check("load_hours", int'(set_hours), 0);
        check("load_minutes", int'(set_minutes), 4);
        check("load_seconds", int'(set_seconds), 56);
        check("load_editing", int'(editing), 1);
        tick(1);
        check("load_gone", int'(load), 0);
        check("editing_fell", int'(editing), 0);
        tick(8);
        check("load_count", load_seen, 1);
        press(0, 0, 1, 0, 6);
        press(1, 0, 0, 0, 6);
        check("idle_seconds", int'(set_seconds), 56);
        check("idle_pos", int'(pos), 4);

        // re-edit, reset mid-edit, recapture, then blink timing
        load_seen = 0;
        set_mod = 1;
        tick(4);
        press(1, 0, 0, 0, 6);
        check("reedit_pos", int'(pos), 1);
        reset = 1;
        tick(1);
        reset = 0;
        check("midrst_editing", int'(editing), 0);
        check("midrst_load", int'(load), 0);
        check("midrst_hours", int'(set_hours), 0);
        check("midrst_pos", int'(pos), 0);
        check("midrst_mask", int'(blink_mask), 0);
        tick(4);
        check("recap_seconds", int'(set_seconds), 56);
        tick(7);
        check("blink_vis_end", int'(blink_mask), 0);
        tick(1);
        check("blink_blank", int'(blink_mask), 1);
        tick(7);
        check("blink_blank_end", int'(blink_mask), 1);
        tick(1);
        check("blink_vis_again", int'(blink_mask), 0);
        tick(3);
        up = 1;
        tick(6);
        up = 0;
        tick(1);
        check("blink_before_press", int'(blink_mask), 1);
        tick(1);
        check("blink_press_vis", int'(blink_mask), 0);
        check("blink_press_sec", int'(set_seconds), 57);
        tick(7);
        check("blink_restart_vis", int'(blink_mask), 0);
        tick(1);
        check("blink_restart_blank", int'(blink_mask), 1);
        check("no_load_on_reset", load_seen, 0);

        // random traffic
        for (int it = 0; it < 300; it++) begin
            rr = $urandom_range(0, 99);
            if (rr < 10) begin
                set_mod = ~set_mod;
                tick($urandom_range(1, 10));
            end else if (rr < 12) begin
                reset = 1;
                tick(1);
                reset = 0;
            end else begin
                cur_hours = 6'($urandom_range(0, 63));
                cur_minutes = 6'($urandom_range(0, 63));
                cur_seconds = 6'($urandom_range(0, 63));
                rr = $urandom_range(0, 15);
                left = rr[0]; right = rr[1]; up = rr[2]; down = rr[3];
                tick($urandom_range(1, 8));
                left = 0; right = 0; up = 0; down = 0;
                tick($urandom_range(0, 12));
            end
        end
        tick(20);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
